// File: rtl/pic_pc_stack_if.sv
// Sequencer-side bundle of the program-counter unit: decode controls in,
// program-memory address plus stack status out.
interface pic_pc_stack_if #(
  parameter int PC_W        = 9,
  parameter int STACK_DEPTH = 8
);
  localparam int SP_W = $clog2(STACK_DEPTH + 1);

  logic            en;
  logic [2:0]      op;
  logic [PC_W-1:0] target;
  logic            clr_err;
  logic [PC_W-1:0] pc_out;
  logic [SP_W-1:0] stack_ptr;
  logic            stack_full;
  logic            stack_empty;
  logic            ovf_err;
  logic            unf_err;
  logic            flush;

  // Decode logic side
  modport master (
    output en, op, target, clr_err,
    input  pc_out, stack_ptr, stack_full, stack_empty, ovf_err, unf_err, flush
  );

  // PC unit side
  modport slave (
    input  en, op, target, clr_err,
    output pc_out, stack_ptr, stack_full, stack_empty, ovf_err, unf_err, flush
  );
endinterface

// File: rtl/pic_pc_stack.sv
// Program-counter sequencer: NEXT/SKIP/GOTO/CALL/RET with a hardware
// return-address stack, sticky overflow/underflow flags and a registered
// flush pulse for the instruction register.
module pic_pc_stack #(
  parameter int              PC_W        = 9,
  parameter int              STACK_DEPTH = 8,
  parameter logic [PC_W-1:0] RESET_VEC   = '0
) (
  input logic          CLK,
  input logic          RST,
  pic_pc_stack_if.slave bus
);
  localparam int SP_W  = $clog2(STACK_DEPTH + 1);
  localparam int IDX_W = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;

  typedef enum logic [2:0] {
    OP_NEXT = 3'd0,
    OP_SKIP = 3'd1,
    OP_GOTO = 3'd2,
    OP_CALL = 3'd3,
    OP_RET  = 3'd4
  } op_e;

  logic [PC_W-1:0]  pc;
  logic [SP_W-1:0]  sp;
  logic             flush_r;
  logic             ovf_r;
  logic             unf_r;
  logic [PC_W-1:0]  stack_mem [STACK_DEPTH];

  op_e              op_dec;
  logic             full;
  logic             empty;
  logic [PC_W-1:0]  pc_inc;
  logic [PC_W-1:0]  pc_inc2;
  logic [IDX_W-1:0] wr_idx;
  logic [IDX_W-1:0] rd_idx;

  logic [PC_W-1:0]  pc_nxt;
  logic [SP_W-1:0]  sp_nxt;
  logic             flush_nxt;
  logic             push;
  logic             ovf_set;
  logic             unf_set;

  assign op_dec  = op_e'(bus.op);
  assign full    = (sp == SP_W'(STACK_DEPTH));
  assign empty   = (sp == '0);
  assign pc_inc  = pc + PC_W'(1);
  assign pc_inc2 = pc + PC_W'(2);
  assign wr_idx  = IDX_W'(sp);
  assign rd_idx  = IDX_W'(sp - SP_W'(1));

  // Next-state decode of the sequencing op; disabled cycles change nothing
  always_comb begin
    pc_nxt    = pc;
    sp_nxt    = sp;
    flush_nxt = 1'b0;
    push      = 1'b0;
    ovf_set   = 1'b0;
    unf_set   = 1'b0;
    if (bus.en) begin
      case (op_dec)
        OP_NEXT: pc_nxt = pc_inc;
        OP_SKIP: begin
          pc_nxt    = pc_inc2;
          flush_nxt = 1'b1;
        end
        OP_GOTO: begin
          pc_nxt    = bus.target;
          flush_nxt = 1'b1;
        end
        OP_CALL: begin
          // A full stack drops the return address but the jump still happens
          pc_nxt    = bus.target;
          flush_nxt = 1'b1;
          if (full) begin
            ovf_set = 1'b1;
          end else begin
            push   = 1'b1;
            sp_nxt = sp + SP_W'(1);
          end
        end
        OP_RET: begin
          // Underflow degrades to a plain increment with no flush
          if (empty) begin
            pc_nxt  = pc_inc;
            unf_set = 1'b1;
          end else begin
            pc_nxt    = stack_mem[rd_idx];
            sp_nxt    = sp - SP_W'(1);
            flush_nxt = 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  // Return-address storage, intentionally left unreset
  always_ff @(posedge CLK) begin
    if (push) stack_mem[wr_idx] <= pc_inc;
  end

  // PC, stack pointer, flush pulse and sticky error flags
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      pc      <= RESET_VEC;
      sp      <= '0;
      flush_r <= 1'b0;
      ovf_r   <= 1'b0;
      unf_r   <= 1'b0;
    end else begin
      pc      <= pc_nxt;
      sp      <= sp_nxt;
      flush_r <= flush_nxt;
      ovf_r   <= ovf_set | (ovf_r & ~bus.clr_err);
      unf_r   <= unf_set | (unf_r & ~bus.clr_err);
    end
  end

  assign bus.pc_out      = pc;
  assign bus.stack_ptr   = sp;
  assign bus.stack_full  = full;
  assign bus.stack_empty = empty;
  assign bus.ovf_err     = ovf_r;
  assign bus.unf_err     = unf_r;
  assign bus.flush       = flush_r;
endmodule

// File: tb/tb_pic_pc_stack.sv
// Scoreboard bench for pic_pc_stack: two configurations (9-bit/8-deep and
// 12-bit/2-deep at 0x100) driven from a queue-based reference model.
module tb_pic_pc_stack;
  localparam int              PW0 = 9;
  localparam int              SD0 = 8;
  localparam logic [PW0-1:0]  RV0 = 9'h000;
  localparam int              PW1 = 12;
  localparam int              SD1 = 2;
  localparam logic [PW1-1:0]  RV1 = 12'h100;

  localparam int OP_NEXT = 0;
  localparam int OP_SKIP = 1;
  localparam int OP_GOTO = 2;
  localparam int OP_CALL = 3;
  localparam int OP_RET  = 4;
  localparam int OP_HOLD = 6;

  logic clk = 1'b0;
  logic clk_run = 1'b0;
  logic rst;

  initial forever begin
    #5;
    if (clk_run) clk = ~clk;
  end

  pic_pc_stack_if #(.PC_W(PW0), .STACK_DEPTH(SD0)) bus0 ();
  pic_pc_stack_if #(.PC_W(PW1), .STACK_DEPTH(SD1)) bus1 ();

  pic_pc_stack #(.PC_W(PW0), .STACK_DEPTH(SD0), .RESET_VEC(RV0)) dut0 (
    .CLK(clk), .RST(rst), .bus(bus0.slave)
  );
  pic_pc_stack #(.PC_W(PW1), .STACK_DEPTH(SD1), .RESET_VEC(RV1)) dut1 (
    .CLK(clk), .RST(rst), .bus(bus1.slave)
  );

  typedef struct {
    int pc;
    int sp;
    int ovf;
    int unf;
    int flush;
    int id;
  } exp_t;

  exp_t q0[$];
  exp_t q1[$];
  int   checks   = 0;
  int   failures = 0;
  int   step_id  = 0;

  int pw_of[2] = '{PW0, PW1};
  int sd_of[2] = '{SD0, SD1};
  int rv_of[2] = '{int'(RV0), int'(RV1)};

  // Reference model: PC as an integer, the stack as a LIFO of return addresses
  int m_pc[2];
  int m_stk0[$];
  int m_stk1[$];
  int m_ovf[2];
  int m_unf[2];

  function automatic void chk(string name, int act, int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endfunction

  function automatic int stk_size(int u);
    return (u == 0) ? m_stk0.size() : m_stk1.size();
  endfunction

  function automatic void model_reset();
    for (int u = 0; u < 2; u++) begin
      m_pc[u]  = rv_of[u];
      m_ovf[u] = 0;
      m_unf[u] = 0;
    end
    m_stk0.delete();
    m_stk1.delete();
  endfunction

  function automatic exp_t model_step(int u, bit en, int op, int tgt, bit clr);
    exp_t e;
    int   mask  = (1 << pw_of[u]) - 1;
    int   flush = 0;
    if (clr) begin
      m_ovf[u] = 0;
      m_unf[u] = 0;
    end
    if (en) begin
      case (op)
        OP_NEXT: m_pc[u] = (m_pc[u] + 1) & mask;
        OP_SKIP: begin m_pc[u] = (m_pc[u] + 2) & mask; flush = 1; end
        OP_GOTO: begin m_pc[u] = tgt & mask; flush = 1; end
        OP_CALL: begin
          if (stk_size(u) < sd_of[u]) begin
            if (u == 0) m_stk0.push_back((m_pc[u] + 1) & mask);
            else        m_stk1.push_back((m_pc[u] + 1) & mask);
          end else begin
            m_ovf[u] = 1;
          end
          m_pc[u] = tgt & mask;
          flush   = 1;
        end
        OP_RET: begin
          if (stk_size(u) > 0) begin
            m_pc[u] = (u == 0) ? m_stk0.pop_back() : m_stk1.pop_back();
            flush   = 1;
          end else begin
            m_pc[u]  = (m_pc[u] + 1) & mask;
            m_unf[u] = 1;
          end
        end
        default: ;
      endcase
    end
    e.pc    = m_pc[u];
    e.sp    = stk_size(u);
    e.ovf   = m_ovf[u];
    e.unf   = m_unf[u];
    e.flush = flush;
    e.id    = step_id;
    return e;
  endfunction

  function automatic void compare(int u, exp_t e);
    int    a_pc, a_sp, a_full, a_empty, a_ovf, a_unf, a_flush;
    string t;
    if (u == 0) begin
      a_pc = int'(bus0.pc_out); a_sp = int'(bus0.stack_ptr);
      a_full = int'(bus0.stack_full); a_empty = int'(bus0.stack_empty);
      a_ovf = int'(bus0.ovf_err); a_unf = int'(bus0.unf_err); a_flush = int'(bus0.flush);
    end else begin
      a_pc = int'(bus1.pc_out); a_sp = int'(bus1.stack_ptr);
      a_full = int'(bus1.stack_full); a_empty = int'(bus1.stack_empty);
      a_ovf = int'(bus1.ovf_err); a_unf = int'(bus1.unf_err); a_flush = int'(bus1.flush);
    end
    t = $sformatf("u%0d#%0d", u, e.id);
    chk({t, " pc"}, a_pc, e.pc);
    chk({t, " stack_ptr"}, a_sp, e.sp);
    chk({t, " stack_full"}, a_full, (e.sp == sd_of[u]) ? 1 : 0);
    chk({t, " stack_empty"}, a_empty, (e.sp == 0) ? 1 : 0);
    chk({t, " ovf_err"}, a_ovf, e.ovf);
    chk({t, " unf_err"}, a_unf, e.unf);
    chk({t, " flush"}, a_flush, e.flush);
  endfunction

  // Immediate check against the model, used when no clock edge is involved
  function automatic void check_now(int u);
    exp_t e;
    e.pc = m_pc[u]; e.sp = stk_size(u); e.ovf = m_ovf[u]; e.unf = m_unf[u];
    e.flush = 0; e.id = -1;
    compare(u, e);
  endfunction

  task automatic apply(int u, bit en, int op, int tgt, bit clr);
    exp_t e;
    @(negedge clk);
    if (u == 0) begin
      bus0.en = en; bus0.op = 3'(op); bus0.target = PW0'(tgt); bus0.clr_err = clr;
      bus1.en = 1'b0; bus1.clr_err = 1'b0;
    end else begin
      bus1.en = en; bus1.op = 3'(op); bus1.target = PW1'(tgt); bus1.clr_err = clr;
      bus0.en = 1'b0; bus0.clr_err = 1'b0;
    end
    e = model_step(u, en, op, tgt, clr);
    step_id++;
    if (u == 0) q0.push_back(e);
    else        q1.push_back(e);
  endtask

  task automatic random_ops(int u, int n);
    int r, op;
    for (int i = 0; i < n; i++) begin
      r = int'($urandom_range(0, 9));
      if (r < 2)       op = OP_NEXT;
      else if (r == 2) op = OP_SKIP;
      else if (r == 3) op = OP_GOTO;
      else if (r < 6)  op = OP_CALL;
      else if (r < 8)  op = OP_RET;
      else             op = int'($urandom_range(5, 7));
      apply(u, $urandom_range(0, 9) != 0, op, int'($urandom), $urandom_range(0, 15) == 0);
    end
  endtask

  task automatic mid_reset(int u, int t_a, int t_b);
    apply(u, 1'b1, OP_CALL, t_a, 1'b0);
    apply(u, 1'b1, OP_CALL, t_b, 1'b0);
    @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    model_reset();
    check_now(0);
    check_now(1);
    rst = 1'b0;
    apply(u, 1'b1, OP_RET, 0, 1'b0);
  endtask

  // Monitor: each stimulus edge produces one observable state to score
  initial forever begin
    @(posedge clk);
    #1;
    if (q0.size() > 0) compare(0, q0.pop_front());
    if (q1.size() > 0) compare(1, q1.pop_front());
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bus0.en = 1'b0; bus0.op = '0; bus0.target = '0; bus0.clr_err = 1'b0;
    bus1.en = 1'b0; bus1.op = '0; bus1.target = '0; bus1.clr_err = 1'b0;

    // Reset with the clock stopped
    rst = 1'b1;
    #3;
    model_reset();
    check_now(0);
    check_now(1);
    rst = 1'b0;
    #1;
    clk_run = 1'b1;

    // Wrap at the top of the address space
    apply(0, 1'b1, OP_GOTO, 510, 1'b0);
    repeat (3) apply(0, 1'b1, OP_NEXT, 0, 1'b0);
    apply(0, 1'b1, OP_GOTO, 510, 1'b0);
    apply(0, 1'b1, OP_SKIP, 0, 1'b0);
    apply(0, 1'b1, OP_NEXT, 0, 1'b0);

    // Nesting to full, overflow, clear racing a new overflow, LIFO unwind
    apply(0, 1'b1, OP_GOTO, 'h80, 1'b0);
    for (int i = 0; i < SD0; i++) apply(0, 1'b1, OP_CALL, 'h10 + i, 1'b0);
    apply(0, 1'b1, OP_CALL, 'h40, 1'b0);
    apply(0, 1'b1, OP_CALL, 'h41, 1'b1);
    apply(0, 1'b1, OP_HOLD, 0, 1'b1);
    for (int i = 0; i < SD0; i++) apply(0, 1'b1, OP_RET, 0, 1'b0);
    apply(0, 1'b1, OP_GOTO, 5, 1'b0);
    apply(0, 1'b1, OP_RET, 0, 1'b0);
    apply(0, 1'b0, OP_HOLD, 0, 1'b1);

    // Enable low holds everything, including a pending GOTO
    repeat (4) apply(0, 1'b0, OP_GOTO, 'h55, 1'b0);
    apply(0, 1'b1, OP_GOTO, 'h55, 1'b0);
    apply(0, 1'b1, OP_CALL, 'h60, 1'b0);
    apply(0, 1'b1, OP_RET, 0, 1'b0);

    // Randomised traffic on both configurations
    random_ops(0, 400);
    apply(1, 1'b1, OP_GOTO, 'hFFF, 1'b0);
    apply(1, 1'b1, OP_SKIP, 0, 1'b0);
    apply(1, 1'b1, OP_CALL, 'hFFF, 1'b0);
    apply(1, 1'b1, OP_CALL, 'h200, 1'b0);
    apply(1, 1'b1, OP_CALL, 'h300, 1'b0);
    apply(1, 1'b1, OP_RET, 0, 1'b0);
    apply(1, 1'b1, OP_RET, 0, 1'b0);
    random_ops(1, 150);

    // Asynchronous reset in the middle of a call sequence
    mid_reset(0, 'h20, 'h30);
    mid_reset(1, 'h123, 'h456);

    @(posedge clk);
    #2;
    chk("drain", q0.size() + q1.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
